uart_stream_transmitter: RTL and testbench
==========================================

// Module: uart_stream_transmitter
// PURPOSE
//  Buffered 8N1 UART transmitter and the FPGA-to-host half of the serial link.
//  Accepts result bytes from the compute pipeline over a valid/ready handshake and queues them in a FIFO.
//  Serialises them LSB-first onto uart_transmit.
//  When APPEND_NULL=1, appends a 0x00 terminator frame after any byte flagged last, matching the host's null-terminated framing.
// PARAMETERS
//  CLOCK_FREQUENCY  100_000_000  system clock in Hz
//  BAUD_RATE        115_200      line rate in bit/s; CYCLES_PER_BIT = CLOCK_FREQUENCY/BAUD_RATE (truncating, must be >= 2)
//  FIFO_DEPTH       16           entries of {last, data[7:0]}; power of two, >= 2
//  APPEND_NULL      1            1: send an extra 0x00 frame after each last byte; 0: never
// PORTS
//  clock           in   1                      system clock, rising edge
//  reset           in   1                      asynchronous, active-low reset
//  data_in         in   8                      byte to transmit
//  data_in_last    in   1                      byte ends a message (terminator follows if APPEND_NULL)
//  data_in_valid   in   1                      producer has a byte
//  data_in_ready   out  1                      FIFO can accept; transfer when valid & ready at clock edge
//  uart_transmit   out  1                      serial line, idle high
//  busy            out  1                      FIFO non-empty or a frame/terminator in progress
//  fifo_count      out  $clog2(FIFO_DEPTH)+1   queued entries, excluding the one in the shifter
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - uart_transmit=1, busy=0, fifo_count=0, data_in_ready=0 while asserted.
//   - FSM=IDLE; any partial frame is abandoned; pending terminator cleared.
//   - data_in_ready=1 from the first edge after release.
//  FIFO:
//   - data_in_ready = (fifo_count < FIFO_DEPTH), registered; no combinational path from valid.
//   - Push and pop in the same cycle leave fifo_count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - The full FIFO never overwrites; a not-ready producer holds.
//  FSM, with bit timer counting CYCLES_PER_BIT-1 down to 0:
//   - IDLE: line=1.
//     - If term_pending: load shifter=0x00, clear term_pending, go to START.
//     - Else if FIFO non-empty: pop, load shifter=data, term_pending<=last&APPEND_NULL, go to START.
//   - START: line=0 for CYCLES_PER_BIT cycles, then DATA with bit_index=0.
//   - DATA: line=shifter[bit_index] for CYCLES_PER_BIT cycles each; after bit 7 go to STOP.
//   - STOP: line=1 for CYCLES_PER_BIT cycles, then IDLE.
//   - Frame = 10*CYCLES_PER_BIT cycles.
//   - IDLE→START costs 1 cycle, so back-to-back frames are separated by exactly 1 idle-high clock.
//  Latency:
//   - Byte accepted into an empty idle block at edge N is popped at N+1.
//   - uart_transmit falls at edge N+2.
//  uart_transmit is driven directly from a flop (glitch-free).
//  busy = (state!=IDLE) | (fifo_count!=0) | term_pending.
//  A terminator is sent even if more bytes are queued behind it.
//  Only last bytes trigger a terminator; last=1 on a 0x00 byte still adds another 0x00.
// TESTING (CLOCK_FREQUENCY=100, BAUD_RATE=10 -> 10 cycles/bit, FIFO_DEPTH=16)
//  1) Send 0x55, last=0:
//     - line low 10 cycles, then bits 1,0,1,0,1,0,1,0 for 10 cycles each, then high 10.
//     - busy falls 101 cycles after the pop edge; no terminator.
//  2) Send 0x41 with last=1, APPEND_NULL=1:
//     - frames 0x41 then 0x00, separated by 1 idle clock.
//     - With APPEND_NULL=0, only 0x41 is sent.
//  3) Hold valid for bytes 0x01..0x14 (20 bytes):
//     - data_in_ready drops when fifo_count=16.
//     - The host decoder receives all 20 bytes in order; none are lost or duplicated.
//  4) Assert reset mid data bit 3 of 0xA5 with 5 bytes queued:
//     - uart_transmit=1 with no clock edge; fifo_count=0; busy=0.
//     - After release, 0x3C transmits cleanly.
//  5) Push and pop in the same cycle at fifo_count=4:
//     - fifo_count stays 4.
//  6) Message 11 22 33 44 55 06 07 08 09 01 01 01 with last on the final byte:
//     - The host read task receives 13 bytes ending 0x00.

Source files
------------

// File: rtl/uart_stream_transmitter.sv
// uart_stream_transmitter
// Buffered 8N1 UART transmitter. Bytes arrive over a valid/ready handshake,
// are queued as {last, data} in a small FIFO and serialised LSB-first.
// With APPEND_NULL set, a 0x00 frame follows every byte flagged last so the
// host sees null-terminated messages. The line and busy are registered from
// the current FSM state, so both lag the state by one clock and stay aligned.
module uart_stream_transmitter #(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 115_200,
    parameter int FIFO_DEPTH      = 16,
    parameter bit APPEND_NULL     = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_last,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic                          uart_transmit,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int TIMER_W        = $clog2(CYCLES_PER_BIT);
    localparam int PTR_W          = $clog2(FIFO_DEPTH);
    localparam int CNT_W          = PTR_W + 1;

    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   DEPTH_C      = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [8:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_ready;

    // Serialiser state
    state_t             r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_term_pending;
    logic               r_tx;
    logic               r_busy;

    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count_next;
    logic [8:0]         w_head;

    // Ready is registered, so a push can only happen into a slot that exists.
    assign w_push = data_in_valid & r_ready;
    // A pending terminator takes priority over the queue head.
    assign w_pop  = (r_state == S_IDLE) & ~r_term_pending & (r_count != '0);
    assign w_head = r_mem[r_rd_ptr];

    // Occupancy after this edge; simultaneous push and pop cancel out.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // FIFO write port; contents need no reset because the count gates reads.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {data_in_last, data_in};
        end
    end

    // FIFO pointers, count and registered ready (pointers wrap naturally).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next < DEPTH_C);
        end
    end

    // Frame FSM with bit timer; line and busy registered from current state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_timer        <= TIMER_RELOAD;
            r_bit_idx      <= 3'd0;
            r_shift        <= 8'h00;
            r_term_pending <= 1'b0;
            r_tx           <= 1'b1;
            r_busy         <= 1'b0;
        end else begin
            r_busy <= (r_state != S_IDLE) | (r_count != '0) | r_term_pending;
            case (r_state)
                S_IDLE: begin
                    r_tx      <= 1'b1;
                    r_timer   <= TIMER_RELOAD;
                    r_bit_idx <= 3'd0;
                    if (r_term_pending) begin
                        r_shift        <= 8'h00;
                        r_term_pending <= 1'b0;
                        r_state        <= S_START;
                    end else if (w_pop) begin
                        r_shift        <= w_head[7:0];
                        r_term_pending <= w_head[8] & APPEND_NULL;
                        r_state        <= S_START;
                    end
                end
                S_START: begin
                    r_tx <= 1'b0;
                    if (r_timer == '0) begin
                        r_timer   <= TIMER_RELOAD;
                        r_bit_idx <= 3'd0;
                        r_state   <= S_DATA;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_DATA: begin
                    r_tx <= r_shift[r_bit_idx];
                    if (r_timer == '0) begin
                        r_timer <= TIMER_RELOAD;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (r_timer == '0) begin
                        r_timer <= TIMER_RELOAD;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_in_ready = r_ready;
    assign uart_transmit = r_tx;
    assign busy          = r_busy;
    assign fifo_count    = r_count;

endmodule

// File: tb/tb_uart_stream_transmitter.sv
// Testbench for uart_stream_transmitter at 10 clocks per bit, 16-entry FIFO.
// A cycle-based line decoder collects received bytes and frame start times;
// a table of short messages is applied first, then hand-written sequences.
module tb_uart_stream_transmitter;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] data_in  = 8'h00;
    logic       last     = 1'b0;
    logic       valid    = 1'b0;
    wire        ready;
    wire        tx;
    wire        busy;
    wire  [4:0] count;

    logic [7:0] data_in1 = 8'h00;
    logic       last1    = 1'b0;
    logic       valid1   = 1'b0;
    wire        ready1;
    wire        tx1;
    wire        busy1;
    wire  [4:0] count1;

    always #5 clock = ~clock;

    uart_stream_transmitter #(
        .CLOCK_FREQUENCY(100), .BAUD_RATE(10), .FIFO_DEPTH(16), .APPEND_NULL(1'b1)
    ) dut (
        .clock(clock), .reset(rst_n),
        .data_in(data_in), .data_in_last(last), .data_in_valid(valid),
        .data_in_ready(ready), .uart_transmit(tx), .busy(busy), .fifo_count(count)
    );

    uart_stream_transmitter #(
        .CLOCK_FREQUENCY(100), .BAUD_RATE(10), .FIFO_DEPTH(16), .APPEND_NULL(1'b0)
    ) dut_nonull (
        .clock(clock), .reset(rst_n),
        .data_in(data_in1), .data_in_last(last1), .data_in_valid(valid1),
        .data_in_ready(ready1), .uart_transmit(tx1), .busy(busy1), .fifo_count(count1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // ---------------- line decoder ----------------
    logic       mon_sel = 1'b0;
    wire        mon_line = mon_sel ? tx1 : tx;
    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         rx_bad = 0;
    int         dec_t  = 0;

    task dec_tick;
        @(negedge clock);
        dec_t++;
    endtask

    initial begin : decoder_p
        logic [7:0] b;
        logic       aborted;
        logic       st;
        logic       sp;
        int         t0;
        forever begin
            dec_tick();
            if (rst_n && mon_line == 1'b0) begin
                t0 = dec_t;
                aborted = 1'b0;
                repeat (4) begin dec_tick(); if (!rst_n) aborted = 1'b1; end
                st = mon_line;
                for (int i = 0; i < 8; i++) begin
                    repeat (10) begin dec_tick(); if (!rst_n) aborted = 1'b1; end
                    b[i] = mon_line;
                end
                repeat (10) begin dec_tick(); if (!rst_n) aborted = 1'b1; end
                sp = mon_line;
                if (!aborted) begin
                    if (st !== 1'b0 || sp !== 1'b1) rx_bad++;
                    rx_q.push_back(b);
                    rx_t.push_back(t0);
                end
            end
        end
    end

    // ---------------- ready/count monitor ----------------
    logic armed;
    int   rdy_viol  = 0;
    int   max_count = 0;

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    always @(negedge clock) begin
        if (rst_n && armed) begin
            if (ready !== (count < 5'd16)) rdy_viol++;
            if (int'(count) > max_count) max_count = int'(count);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [7:0] d, input logic l);
        int n = 0;
        @(negedge clock);
        data_in = d;
        last    = l;
        valid   = 1'b1;
        while (ready !== 1'b1 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: ready=%b, expected 1 within 3000 cycles", ready);
        end
        @(posedge clock);
    endtask

    task automatic idle_in;
        @(negedge clock);
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        repeat (3) @(negedge clock);
        while (busy !== 1'b0 && n < 20000) begin
            @(negedge clock);
            n++;
        end
        check({name, "_drain"}, busy, 0);
        repeat (2) @(negedge clock);
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp[$]);
        int bad = 0;
        check({name, "_rx_len"}, rx_q.size(), exp.size());
        foreach (exp[i]) begin
            if (i >= rx_q.size() || rx_q[i] !== exp[i]) bad++;
        end
        check({name, "_rx_bytes_bad"}, bad, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] d0;
        logic       l0;
        logic       two;
        logic [7:0] d1;
        logic       l1;
        int         n;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;

    vec_t vecs[6];

    initial begin : main_p
        logic [7:0] exp_q[$];
        logic [9:0] frame;
        int         errs;
        int         bad;
        int         n;

        vecs[0] = '{8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1, 8'h55, 8'h00, 8'h00};
        vecs[1] = '{8'h41, 1'b1, 1'b0, 8'h00, 1'b0, 2, 8'h41, 8'h00, 8'h00};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 2, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{8'h41, 1'b1, 1'b1, 8'h42, 1'b0, 3, 8'h41, 8'h00, 8'h42};
        vecs[4] = '{8'hA5, 1'b0, 1'b1, 8'hFF, 1'b1, 3, 8'hA5, 8'hFF, 8'h00};
        vecs[5] = '{8'h80, 1'b0, 1'b1, 8'h01, 1'b0, 2, 8'h80, 8'h01, 8'h00};

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_line", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_count", count, 0);
        check("reset_ready", ready, 0);
        rst_n = 1'b1;
        @(negedge clock);
        check("ready_after_release", ready, 1);

        // Table-driven messages
        for (int v = 0; v < 6; v++) begin
            rx_q.delete();
            rx_t.delete();
            push(vecs[v].d0, vecs[v].l0);
            if (vecs[v].two) push(vecs[v].d1, vecs[v].l1);
            idle_in();
            wait_done($sformatf("vec%0d", v));
            exp_q.delete();
            exp_q.push_back(vecs[v].e0);
            if (vecs[v].n > 1) exp_q.push_back(vecs[v].e1);
            if (vecs[v].n > 2) exp_q.push_back(vecs[v].e2);
            check_rx($sformatf("vec%0d", v), exp_q);
            bad = 0;
            for (int j = 1; j < rx_t.size(); j++) begin
                if (rx_t[j] - rx_t[j-1] != 101) bad++;
            end
            check($sformatf("vec%0d_frame_spacing_bad", v), bad, 0);
        end

        // 1) 0x55 waveform, latency and busy fall
        rx_q.delete();
        rx_t.delete();
        push(8'h55, 1'b0);
        idle_in();
        check("t1_line_high_after_accept", tx, 1);
        @(negedge clock);
        check("t1_count_after_pop", count, 0);
        check("t1_busy_at_pop", busy, 1);
        check("t1_line_high_at_pop", tx, 1);
        frame = {1'b1, 8'h55, 1'b0};
        for (int s = 0; s < 10; s++) begin
            errs = 0;
            repeat (10) begin
                @(negedge clock);
                if (tx !== frame[s]) errs++;
            end
            check($sformatf("t1_slot%0d_bad_cycles", s), errs, 0);
        end
        check("t1_busy_100_after_pop", busy, 1);
        @(negedge clock);
        check("t1_busy_101_after_pop", busy, 0);
        check("t1_line_idle", tx, 1);
        repeat (150) @(negedge clock);
        exp_q = '{8'h55};
        check_rx("t1", exp_q);

        // 2) last byte without terminator on the APPEND_NULL=0 instance
        mon_sel = 1'b1;
        rx_q.delete();
        rx_t.delete();
        @(negedge clock);
        data_in1 = 8'h41;
        last1    = 1'b1;
        valid1   = 1'b1;
        check("t2_nonull_ready", ready1, 1);
        @(posedge clock);
        @(negedge clock);
        valid1 = 1'b0;
        n = 0;
        repeat (300) begin
            @(negedge clock);
            if (busy1 === 1'b1) n++;
        end
        check("t2_nonull_busy_cycles", n, 101);
        exp_q = '{8'h41};
        check_rx("t2_nonull", exp_q);
        mon_sel = 1'b0;

        // 3) 20 bytes with valid held; FIFO fills and back-pressures
        rx_q.delete();
        rx_t.delete();
        max_count = 0;
        for (int i = 1; i <= 20; i++) push(8'(i), 1'b0);
        idle_in();
        wait_done("t3");
        check("t3_max_count", max_count, 16);
        exp_q.delete();
        for (int i = 1; i <= 20; i++) exp_q.push_back(8'(i));
        check_rx("t3", exp_q);

        // 5) push and pop on the same edge at fifo_count=4
        rx_q.delete();
        rx_t.delete();
        push(8'hA0, 1'b0);
        push(8'hB1, 1'b0);
        push(8'hC2, 1'b0);
        push(8'hD3, 1'b0);
        push(8'hE4, 1'b0);
        idle_in();
        check("t5_count_queued", count, 4);
        repeat (96) @(negedge clock);
        check("t5_count_before_pop", count, 4);
        push(8'hF5, 1'b0);
        @(negedge clock);
        check("t5_count_push_pop", count, 4);
        valid = 1'b0;
        wait_done("t5");
        exp_q = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 8'hF5};
        check_rx("t5", exp_q);

        // 6) 12-byte message with terminator
        rx_q.delete();
        rx_t.delete();
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h06, 8'h07, 8'h08, 8'h09, 8'h01, 8'h01, 8'h01};
        foreach (exp_q[i]) push(exp_q[i], (i == 11) ? 1'b1 : 1'b0);
        idle_in();
        wait_done("t6");
        exp_q.push_back(8'h00);
        check_rx("t6", exp_q);

        // 4) asynchronous reset in data bit 3 of 0xA5 with 5 bytes queued
        rx_q.delete();
        rx_t.delete();
        push(8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), 1'b0);
        idle_in();
        repeat (40) @(negedge clock);
        check("t4_line_bit3", tx, 0);
        check("t4_count_queued", count, 5);
        #2 rst_n = 1'b0;
        #1;
        check("t4_reset_line", tx, 1);
        check("t4_reset_count", count, 0);
        check("t4_reset_busy", busy, 0);
        check("t4_reset_ready", ready, 0);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        check("t4_ready_after_release", ready, 1);
        repeat (110) @(negedge clock);
        check("t4_rx_after_abort", rx_q.size(), 0);
        push(8'h3C, 1'b0);
        idle_in();
        wait_done("t4");
        exp_q = '{8'h3C};
        check_rx("t4", exp_q);

        check("ready_vs_count_violations", rdy_viol, 0);
        check("framing_errors", rx_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog_p
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
